// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/sub over one shared P/G full-adder slice; group P/G for lookahead; optional ovf via SERIAL_OVF_EN.
// Latency: start at edge k -> busy after k+1..k+WIDTH, done pulse after k+WIDTH+1, next start at k+WIDTH+2.
// Backpressure: none queued; start is only sampled in IDLE and ignored while RUN/DONE.
module serial_addsub_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             grp_p,
  output logic             grp_g
`ifdef SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               carry, p_acc, g_acc;
  logic               load, step, last;
  logic               p_bit, g_bit, s_bit, c_nxt, p_nxt, g_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        load      = 1'b1;
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are shifted right each RUN cycle so the slice always reads bit 0.
  assign p_bit = a_q[0] ^ b_q[0];
  assign g_bit = a_q[0] & b_q[0];
  assign s_bit = p_bit ^ carry;
  assign c_nxt = g_bit | (p_bit & carry);
  assign p_nxt = p_acc & p_bit;
  assign g_nxt = g_bit | (p_bit & g_acc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      p_acc  <= 1'b0;
      g_acc  <= 1'b0;
      result <= '0;
      c_out  <= 1'b0;
      grp_p  <= 1'b0;
      grp_g  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SERIAL_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      busy <= (state == RUN);
      done <= (state == DONE);
      if (load) begin
        a_q   <= a;
        b_q   <= sub ? ~b : b;
        carry <= sub;
        cnt   <= '0;
        p_acc <= 1'b1;
        g_acc <= 1'b0;
      end else if (step) begin
        a_q    <= a_q >> 1;
        b_q    <= b_q >> 1;
        result <= {s_bit, result[WIDTH-1:1]};
        carry  <= c_nxt;
        p_acc  <= p_nxt;
        g_acc  <= g_nxt;
        cnt    <= cnt + CNT_W'(1);
        if (last) begin
          c_out <= c_nxt;
          grp_p <= p_nxt;
          grp_g <= g_nxt;
`ifdef SERIAL_OVF_EN
          // Carry into the MSB is the current carry; carry out is c_nxt.
          ovf   <= carry ^ c_nxt;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl (WIDTH=4): cycle-exact busy/done, results, back-to-back start, mid-run reset.
module tb_serial_addsub_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, c_out, grp_p, grp_g;
  logic [W-1:0] result;
  logic         ovf_obs;
  int           n_cmp = 0;
  int           n_err = 0;

`ifdef SERIAL_OVF_EN
  logic ovf;
  assign ovf_obs = ovf;
`else
  assign ovf_obs = 1'b0;
`endif

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .grp_p  (grp_p),
    .grp_g  (grp_g)
`ifdef SERIAL_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller sits at a negedge. Inputs are scrambled right after the start edge;
  // keep_start leaves start high so early re-acceptance would show in busy/done.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ts, input logic keep_start);
    start = 1'b1; a = ta; b = tb; sub = ts;
    @(posedge clk);
    for (int i = 0; i <= W + 1; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (!keep_start) start = 1'b0;
        a = ~ta; b = ~tb; sub = ~ts;
      end
      check($sformatf("%s busy@%0d", tag, i), 32'(busy), 32'(i >= 1 && i <= W));
      check($sformatf("%s done@%0d", tag, i), 32'(done), 32'(i == W + 1));
    end
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] r, input logic co,
                           input logic p, input logic g, input logic ov);
    check({tag, " result"}, 32'(result), 32'(r));
    check({tag, " c_out"},  32'(c_out),  32'(co));
    check({tag, " grp_p"},  32'(grp_p),  32'(p));
    check({tag, " grp_g"},  32'(grp_g),  32'(g));
`ifdef SERIAL_OVF_EN
    check({tag, " ovf"},    32'(ovf_obs), 32'(ov));
`else
    if (ov !== ov) check({tag, " ovf"}, 32'(ovf_obs), 32'(ov));
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check_res(tag, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    run_op("add5p3", 4'b0101, 4'b0011, 1'b0, 1'b0);
    check_res("add5p3", 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1);

    run_op("sub3m5", 4'b0011, 4'b0101, 1'b1, 1'b0);
    check_res("sub3m5", 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0);

    run_op("addFp1", 4'b1111, 4'b0001, 1'b0, 1'b0);
    check_res("addFp1", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);

    run_op("addAp5", 4'b1010, 4'b0101, 1'b0, 1'b0);
    check_res("addAp5", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);

    run_op("sub6m6", 4'b0110, 4'b0110, 1'b1, 1'b0);
    check_res("sub6m6", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);

    // Results hold through idle cycles.
    repeat (3) @(negedge clk);
    check_res("hold", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);

    // start held high across two back-to-back operations.
    run_op("b2b_1", 4'b0101, 4'b0011, 1'b0, 1'b1);
    check_res("b2b_1", 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("b2b_2", 4'b1111, 4'b1111, 1'b1, 1'b0);
    check_res("b2b_2", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);

    // Load a nonzero result, then reset during the second RUN cycle.
    run_op("pre_rst", 4'b0101, 4'b0011, 1'b0, 1'b0);
    start = 1'b1; a = 4'b0011; b = 4'b0101; sub = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      check($sformatf("no_done@%0d", i), 32'(done), 32'd0);
    end

    run_op("post_rst", 4'b1010, 4'b0101, 1'b0, 1'b0);
    check_res("post_rst", 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, observed stall required completion");
    $fatal(1, "timeout");
  end

endmodule
